// File: rtl/s2p_pkg.sv
// s2p_pkg: shared state encoding and counter sizing for the serial_to_parallel deserialiser.
package s2p_pkg;
  typedef enum logic {ST_IDLE, ST_SHIFT} state_e;
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/s2p_hold_reg.sv
// s2p_hold_reg: one-word valid/ready holding register with load, consume and overflow detection.
module s2p_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             ovf_o
);
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d, ovf_q, ovf_d, accept;
  // A load is accepted when the slot is empty or is being drained on this same edge.
  always_comb begin
    accept  = !valid_q || ready_i;
    data_d  = (load_i && accept) ? data_i : data_q;
    valid_d = load_i || (valid_q && !ready_i);
    ovf_d   = load_i && !accept;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign ovf_o   = ovf_q;
endmodule

// File: rtl/serial_to_parallel.sv
// serial_to_parallel: deserialiser assembling WIDTH valid-qualified serial bits into a word,
// presented through a one-word ready/valid holding register with gap and overflow reporting.
module serial_to_parallel
  import s2p_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter bit MSB_FIRST    = 1'b1,
  parameter bit ABORT_ON_GAP = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             din_serial,
  input  logic             din_valid,
  output logic [WIDTH-1:0] dout_parallel,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overflow_err
);
  localparam int             CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sh_q, sh_nxt;
  logic             busy_q, ferr_q, done;
  assign sh_nxt = MSB_FIRST ? {sh_q[WIDTH-2:0], din_serial} : {din_serial, sh_q[WIDTH-1:1]};
  assign done   = din_valid && (cnt_q == LAST);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      busy_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      ferr_q <= 1'b0;
      if (din_valid) begin
        sh_q    <= sh_nxt;
        cnt_q   <= done ? '0 : cnt_q + CW'(1);
        busy_q  <= !done;
        state_q <= done ? ST_IDLE : ST_SHIFT;
      end else if (state_q == ST_SHIFT && ABORT_ON_GAP) begin
        cnt_q   <= '0;
        busy_q  <= 1'b0;
        state_q <= ST_IDLE;
        ferr_q  <= 1'b1;
      end
    end
  // The completing bit is folded in combinationally so the whole word loads on its own edge.
  s2p_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk    (clk),
    .rstn   (rstn),
    .load_i (done),
    .data_i (sh_nxt),
    .ready_i(dout_ready),
    .data_o (dout_parallel),
    .valid_o(dout_valid),
    .ovf_o  (overflow_err)
  );
  assign busy      = busy_q;
  assign frame_err = ferr_q;
endmodule

// File: doc/serial_to_parallel.md
Name: serial_to_parallel

Overview:
Deserialiser forming the receive end of the team's 8-bit serial link. It accepts one bit per clock, qualified by din_valid, and assembles the bits into a WIDTH-bit word. It presents each completed word on a registered ready/valid output with a one-word holding register. It sits directly downstream of parallel_to_serial and reports framing gaps and overflow.

Parameters:
WIDTH, 8, word width in bits (2..32)
MSB_FIRST, 1, 1 = first received bit lands in bit WIDTH-1; 0 = first bit lands in bit 0
ABORT_ON_GAP, 1, 1 = din_valid low mid-word discards the partial word; 0 = the partial word is held and resumes

Ports:
clk  input  1  system clock, all logic on rising edge
rstn  input  1  asynchronous active-low reset
din_serial  input  1  serial data bit
din_valid  input  1  din_serial is valid this cycle
dout_parallel  output  WIDTH  assembled word, stable while dout_valid=1
dout_valid  output  1  holding register holds an unconsumed word
dout_ready  input  1  consumer accepts the word when dout_valid & dout_ready
busy  output  1  a partial word is in progress (bit count != 0)
frame_err  output  1  one-cycle pulse: partial word discarded on gap
overflow_err  output  1  one-cycle pulse: completed word dropped because holding register full

Behaviour:
- Reset (async assert, sync release): dout_parallel=0, dout_valid=0, busy=0, frame_err=0, overflow_err=0, shift register=0, bit count=0, state=IDLE.
- States:
  - IDLE (count=0).
  - SHIFT (0<count<WIDTH).
  - IDLE -> SHIFT on a din_valid edge when WIDTH>1.
  - SHIFT -> IDLE on word completion or on abort.
- Capture: each rising edge with din_valid=1 shifts din_serial in and increments count.
  - MSB_FIRST=1: shift left, new bit into LSB.
  - MSB_FIRST=0: shift right, new bit into MSB.
- Completion: on the edge capturing bit WIDTH, the word (including that bit) moves to the holding register, count returns to 0, and dout_valid=1 from the following cycle. Latency is one cycle after the last valid bit cycle.
- Back-to-back words: a valid bit in the cycle after completion starts the next word. No idle cycle is required, so full throughput is one word per WIDTH cycles.
- Output handshake: the word is consumed on an edge with dout_valid & dout_ready. dout_valid then falls unless a new word completes on the same edge.
  - Simultaneous consume and complete: the new word is loaded, dout_valid stays 1, and no overflow is flagged.
- Overflow: a word completes while dout_valid=1 and dout_ready=0.
  - The new word is dropped; the held word is kept unchanged.
  - overflow_err pulses for 1 cycle; count still resets to 0.
- Gap:
  - ABORT_ON_GAP=1: din_valid=0 while state=SHIFT resets count to 0, returns to IDLE, and pulses frame_err for 1 cycle. Shift register contents are don't-care.
  - ABORT_ON_GAP=0: count and the shift register hold.
  - din_valid=0 in IDLE has no effect.
- busy = (count != 0), registered.
- dout_parallel changes only on load. It is never modified while dout_valid=1 except by a same-edge consume+load.
- Reset mid-word or with a word held: everything clears asynchronously. No error pulse is generated.
- Count width is $clog2(WIDTH+1) bits and never exceeds WIDTH.

Decomposition:
- Shared package s2p_pkg: state enum (ST_IDLE, ST_SHIFT) and the count-width function.
- One natural sub-module: s2p_hold_reg, the one-word valid/ready holding register with load, consume and overflow detection.
- The shift register, counter and FSM live in the top.

Test Plan:
- Reset, then din_valid=1 for 8 cycles with bits 1,1,1,1,0,0,0,0 and dout_ready=1 -> dout_parallel=8'hF0, dout_valid=1 exactly one cycle after the 8th bit, for one cycle; busy high for cycles 1-7.
- Back-to-back 0xF0 then 0xA3 (bits 1,0,1,0,0,0,1,1), din_valid continuous for 16 cycles -> two one-cycle valid pulses 8 cycles apart carrying 8'hF0 then 8'hA3; no errors.
- din_valid drops after 5 bits, then 8 bits of 0xA3 -> frame_err pulses once in the cycle after the drop; output shows only 8'hA3.
- dout_ready=0, two full words 0xF0 then 0x0F -> dout_valid=1 holding 8'hF0; overflow_err pulses once at the 2nd completion; after dout_ready=1, 8'hF0 is consumed and dout_valid falls.
- dout_ready asserted on the same edge the 2nd word completes -> 8'hF0 consumed, 8'h0F loaded, dout_valid stays 1, no overflow.
- rstn pulsed low after 4 bits -> all outputs 0 immediately; the next 8 bits of 0xA3 produce 8'hA3 (MSB_FIRST=1); rerun with MSB_FIRST=0 expecting 8'hC5.
